// File: rtl/scan_decoder_n.sv
// scan_decoder_n
//   Registered N-to-2^N decoder with 74LS138-style enables. It drives the digit-select
//   lines of multiplexed displays. In manual mode it decodes the address input. In
//   auto-scan mode it steps through indices 0..last: each index is held for DIV clocks,
//   and BLANK dead-time clocks separate consecutive slots.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high, overrides every other input
//   g1          enable, active-high
//   g2a_n       enable, active-low
//   g2b_n       enable, active-low
//   mode        0 = manual decode, 1 = auto-scan
//   address     manual-mode select
//   last        highest index visited in scan mode
//   outputs     decoded select lines (registered)
//   cur_addr    index currently driven, held while blanked or off
//   frame_done  one-cycle pulse after the scan wraps back to index 0
//
// state   | meaning
// S_OFF   | disabled, all lines inactive
// S_DRIVE | one line active for cur_addr
// S_BLANK | dead time between slots, all lines inactive
`timescale 1ns/1ps

module scan_decoder_n #(
    parameter int ADDR_W     = 3,
    parameter int DIV        = 4,
    parameter int BLANK      = 1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   g1,
    input  logic                   g2a_n,
    input  logic                   g2b_n,
    input  logic                   mode,
    input  logic [ADDR_W-1:0]      address,
    input  logic [ADDR_W-1:0]      last,
    output logic [(2**ADDR_W)-1:0] outputs,
    output logic [ADDR_W-1:0]      cur_addr,
    output logic                   frame_done
);

    localparam int N_OUT = 2**ADDR_W;
    localparam int SW    = $clog2(DIV + 1);
    // A zero-width counter is illegal. With BLANK = 0 the blank counter keeps one bit,
    // but the S_BLANK state is never entered.
    localparam int BW    = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

    localparam logic [SW-1:0]    SLOT_LAST  = SW'(DIV - 1);
    localparam logic [BW-1:0]    BLANK_LAST = BW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [N_OUT-1:0] IDLE       = {N_OUT{ACTIVE_LOW}};

    typedef enum logic [1:0] {S_OFF, S_DRIVE, S_BLANK} state_t;

    state_t             state_q;
    logic [N_OUT-1:0]   outputs_q;
    logic [ADDR_W-1:0]  cur_addr_q;
    logic               frame_done_q;
    logic [SW-1:0]      slot_cnt_q;
    logic [BW-1:0]      blank_cnt_q;
    logic               mode_q;
    // Set after a mode change, so that the scan restarts at index 0 instead of stepping.
    logic               restart_q;

    logic               en;
    logic               wrap;
    logic [ADDR_W-1:0]  scan_next;
    logic [ADDR_W-1:0]  entry_addr;

    function automatic logic [N_OUT-1:0] decode(input logic [ADDR_W-1:0] a);
        logic [N_OUT-1:0] w;
        w    = IDLE;
        w[a] = ~w[a];
        return w;
    endfunction

    always_comb begin
        en         = g1 & ~g2a_n & ~g2b_n;
        // A ">=" comparison makes a runtime shrink of last wrap cleanly.
        wrap       = (cur_addr_q >= last);
        scan_next  = wrap ? '0 : cur_addr_q + 1'b1;
        entry_addr = mode ? '0 : address;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_OFF;
            outputs_q    <= IDLE;
            cur_addr_q   <= '0;
            frame_done_q <= 1'b0;
            slot_cnt_q   <= '0;
            blank_cnt_q  <= '0;
            mode_q       <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            mode_q       <= mode;
            frame_done_q <= 1'b0;
            if (!en) begin
                state_q     <= S_OFF;
                outputs_q   <= IDLE;
                slot_cnt_q  <= '0;
                blank_cnt_q <= '0;
                restart_q   <= 1'b0;
            end else if (state_q != S_OFF && mode != mode_q) begin
                slot_cnt_q  <= '0;
                blank_cnt_q <= '0;
                if (BLANK == 0) begin
                    state_q    <= S_DRIVE;
                    cur_addr_q <= entry_addr;
                    outputs_q  <= decode(entry_addr);
                    restart_q  <= 1'b0;
                end else begin
                    state_q   <= S_BLANK;
                    outputs_q <= IDLE;
                    restart_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    S_OFF: begin
                        state_q     <= S_DRIVE;
                        cur_addr_q  <= entry_addr;
                        outputs_q   <= decode(entry_addr);
                        slot_cnt_q  <= '0;
                        blank_cnt_q <= '0;
                        restart_q   <= 1'b0;
                    end
                    S_DRIVE: begin
                        if (!mode) begin
                            if (address != cur_addr_q) begin
                                if (BLANK == 0) begin
                                    cur_addr_q <= address;
                                    outputs_q  <= decode(address);
                                end else begin
                                    state_q     <= S_BLANK;
                                    outputs_q   <= IDLE;
                                    blank_cnt_q <= '0;
                                end
                            end
                        end else if (slot_cnt_q == SLOT_LAST) begin
                            slot_cnt_q <= '0;
                            if (BLANK == 0) begin
                                cur_addr_q   <= scan_next;
                                outputs_q    <= decode(scan_next);
                                frame_done_q <= wrap;
                            end else begin
                                state_q     <= S_BLANK;
                                outputs_q   <= IDLE;
                                blank_cnt_q <= '0;
                            end
                        end else begin
                            slot_cnt_q <= slot_cnt_q + 1'b1;
                        end
                    end
                    S_BLANK: begin
                        if (blank_cnt_q == BLANK_LAST) begin
                            state_q     <= S_DRIVE;
                            blank_cnt_q <= '0;
                            slot_cnt_q  <= '0;
                            restart_q   <= 1'b0;
                            if (!mode) begin
                                cur_addr_q <= address;
                                outputs_q  <= decode(address);
                            end else if (restart_q) begin
                                cur_addr_q <= '0;
                                outputs_q  <= decode('0);
                            end else begin
                                cur_addr_q   <= scan_next;
                                outputs_q    <= decode(scan_next);
                                frame_done_q <= wrap;
                            end
                        end else begin
                            blank_cnt_q <= blank_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= S_OFF;
                        outputs_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign outputs    = outputs_q;
    assign cur_addr   = cur_addr_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_decoder_n.sv
`timescale 1ns/1ps

module tb_scan_decoder_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a: DIV=1, BLANK=0 (plain registered '138); dut_b: DIV=4, BLANK=1
    logic       a_rst, a_g1, a_g2a_n, a_g2b_n, a_mode;
    logic [2:0] a_address, a_last;
    logic [7:0] a_out;
    logic [2:0] a_cur;
    logic       a_fd;

    logic       b_rst, b_g1, b_g2a_n, b_g2b_n, b_mode;
    logic [2:0] b_address, b_last;
    logic [7:0] b_out;
    logic [2:0] b_cur;
    logic       b_fd;

    scan_decoder_n #(.ADDR_W(3), .DIV(1), .BLANK(0), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(a_rst), .g1(a_g1), .g2a_n(a_g2a_n), .g2b_n(a_g2b_n),
        .mode(a_mode), .address(a_address), .last(a_last),
        .outputs(a_out), .cur_addr(a_cur), .frame_done(a_fd)
    );

    scan_decoder_n #(.ADDR_W(3), .DIV(4), .BLANK(1), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(b_rst), .g1(b_g1), .g2a_n(b_g2a_n), .g2b_n(b_g2b_n),
        .mode(b_mode), .address(b_address), .last(b_last),
        .outputs(b_out), .cur_addr(b_cur), .frame_done(b_fd)
    );

    typedef struct {
        int         sel;
        int         id;
        logic [7:0] out;
        logic [2:0] cur;
        logic       fd;
    } exp_t;

    typedef struct {
        logic       g1;
        logic       g2a_n;
        logic       g2b_n;
        logic [2:0] addr;
        logic [7:0] out;
        logic [2:0] cur;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %0h want %0h", name, id, act, exp);
        end
    endtask

    function automatic void push(input int sel, input int id, input logic [7:0] o,
                                 input logic [2:0] c, input logic fd);
        exp_t e;
        e.sel = sel; e.id = id; e.out = o; e.cur = c; e.fd = fd;
        sb.push_back(e);
    endfunction

    // Expected dut_b scan output at cycle t after enable, DIV=4 and BLANK=1, so each slot is 5 cycles
    function automatic exp_t scan_model(input int t, input int lst, input int id);
        exp_t       e;
        logic [7:0] one;
        int         per, p, idx, w;
        one   = 8'd1;
        per   = 5 * (lst + 1);
        p     = t % per;
        idx   = p / 5;
        w     = p % 5;
        e.sel = 1;
        e.id  = id;
        e.out = (w < 4) ? ~(one << idx) : 8'hFF;
        e.cur = idx[2:0];
        e.fd  = (p == 0 && t >= per);
        return e;
    endfunction

    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 0) begin
                chk("a_out", e.id, a_out, e.out);
                chk("a_cur", e.id, {5'd0, a_cur}, {5'd0, e.cur});
                chk("a_fd",  e.id, {7'd0, a_fd}, {7'd0, e.fd});
            end else begin
                chk("b_out", e.id, b_out, e.out);
                chk("b_cur", e.id, {5'd0, b_cur}, {5'd0, e.cur});
                chk("b_fd",  e.id, {7'd0, b_fd}, {7'd0, e.fd});
            end
        end
    endtask

    task automatic run_scan(input int t0, input int t1, input int lst, input int shift, input int id0);
        for (int t = t0; t <= t1; t++) begin
            sb.push_back(scan_model(t - shift, lst, id0 + t));
            cyc();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd5, 8'hDF, 3'd5};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 3'd5, 8'hFF, 3'd5};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'hFE, 3'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd7, 8'h7F, 3'd7};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 3'd3, 8'hFF, 3'd7};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 3'd2, 8'hFF, 3'd7};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd3, 8'hF7, 3'd3};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'd6, 8'hBF, 3'd6};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'd1, 8'hFD, 3'd1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'd4, 8'hEF, 3'd4};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 3'd4, 8'hFF, 3'd4};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 3'd2, 8'hFB, 3'd2};

        a_rst = 1'b1; a_g1 = 1'b0; a_g2a_n = 1'b0; a_g2b_n = 1'b0;
        a_mode = 1'b0; a_address = 3'd0; a_last = 3'd0;
        b_rst = 1'b1; b_g1 = 1'b1; b_g2a_n = 1'b0; b_g2b_n = 1'b0;
        b_mode = 1'b1; b_address = 3'd0; b_last = 3'd2;

        // Reset held two cycles while enabled in scan mode
        push(1, 1, 8'hFF, 3'd0, 1'b0); cyc();
        push(1, 2, 8'hFF, 3'd0, 1'b0); cyc();

        // Manual decode truth table on dut_a
        a_rst = 1'b0;
        push(0, 10, 8'hFF, 3'd0, 1'b0); cyc();
        for (int i = 0; i < 12; i++) begin
            a_g1 = tbl[i].g1; a_g2a_n = tbl[i].g2a_n; a_g2b_n = tbl[i].g2b_n;
            a_address = tbl[i].addr;
            push(0, 20 + i, tbl[i].out, tbl[i].cur, 1'b0);
            cyc();
        end

        // Manual with blanking on dut_b: 2 -> 6
        b_rst = 1'b0; b_mode = 1'b0; b_address = 3'd2;
        push(1, 40, 8'hFB, 3'd2, 1'b0); cyc();
        b_address = 3'd6;
        push(1, 41, 8'hFF, 3'd2, 1'b0); cyc();
        push(1, 42, 8'hBF, 3'd6, 1'b0); cyc();
        push(1, 43, 8'hBF, 3'd6, 1'b0); cyc();

        // Mode toggle to scan: one blank cycle, then restart at index 0 without a frame pulse
        b_mode = 1'b1;
        push(1, 44, 8'hFF, 3'd6, 1'b0); cyc();
        run_scan(0, 19, 2, 0, 100);

        // Mode toggle back to manual during a blank cycle
        b_mode = 1'b0; b_address = 3'd3;
        push(1, 45, 8'hFF, 3'd0, 1'b0); cyc();
        push(1, 46, 8'hF7, 3'd3, 1'b0); cyc();

        // Scan DIV=4 BLANK=1 last=2 from reset
        b_rst = 1'b1; b_mode = 1'b1; b_last = 3'd2;
        push(1, 47, 8'hFF, 3'd0, 1'b0); cyc();
        b_rst = 1'b0;
        run_scan(0, 51, 2, 0, 200);

        // Drop enable mid-slot, then re-enable
        b_g1 = 1'b0;
        push(1, 48, 8'hFF, 3'd1, 1'b0); cyc();
        push(1, 49, 8'hFF, 3'd1, 1'b0); cyc();
        b_g1 = 1'b1;
        run_scan(0, 11, 2, 0, 300);

        // Reset mid-scan, then restart
        b_rst = 1'b1;
        push(1, 50, 8'hFF, 3'd0, 1'b0); cyc();
        b_rst = 1'b0;
        run_scan(0, 9, 2, 0, 400);

        // last=7 shrunk to 1 while index 5 is driven
        b_rst = 1'b1;
        push(1, 51, 8'hFF, 3'd0, 1'b0); cyc();
        b_rst = 1'b0; b_last = 3'd7;
        run_scan(0, 26, 7, 0, 500);
        b_last = 3'd1;
        run_scan(27, 29, 7, 0, 500);
        run_scan(30, 49, 1, 20, 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
